// File: rtl/criscv_mem_bridge.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | criscv_mem_bridge: core memory port to word-wide byte-enabled backend, with |
// | misalignment flag; MMIO bank when CRISCV_BRIDGE_MMIO_EN is defined. Rev 1.0 |
// +-----------------------------------------------------------------------------+
module criscv_mem_bridge #(
  parameter int ADDR_W = 16
) (
  input  logic              mclk,
  input  logic              reset,
  input  logic [31:0]       mem_address,
  input  logic              mem_rw_req,
  input  logic              mem_rw,
  input  logic [31:0]       mem_write_data,
  input  logic [1:0]        mem_size,
  output logic [31:0]       mem_read_data,
  output logic              mem_rec,
  output logic [ADDR_W-3:0] ram_addr,
  output logic              ram_req,
  output logic              ram_we,
  output logic [3:0]        ram_be,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  input  logic              ram_ack,
  input  logic [7:0]        gpio_in,
  output logic [7:0]        gpio_out,
  output logic              err,
  output logic [31:0]       err_addr
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RAM_WAIT = 3'd1,
    S_LOCAL    = 3'd2,
    S_RESP     = 3'd3,
    S_RELEASE  = 3'd4
  } state_t;

  state_t      r_state;
  logic [1:0]  r_lane;
  logic [1:0]  r_size;
  logic        r_rw;
  logic        r_misal;
  logic        w_misal;
  logic        w_mmio;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_local_rdata;

  function automatic logic [31:0] lane_align(input logic [31:0] word,
                                             input logic [1:0]  lane,
                                             input logic [1:0]  size);
    logic [31:0] shifted;
    shifted = word >> {lane, 3'b000};
    case (size)
      2'd0:    lane_align = {24'h0, shifted[7:0]};
      2'd1:    lane_align = {16'h0, shifted[15:0]};
      default: lane_align = shifted;
    endcase
  endfunction

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = mem_write_data;
    w_misal = ((mem_size == 2'd1) && mem_address[0]) ||
              (mem_size[1] && (mem_address[1:0] != 2'b00));
    case (mem_size)
      2'd0: begin
        w_be    = 4'b0001 << mem_address[1:0];
        w_wdata = {4{mem_write_data[7:0]}};
      end
      2'd1: begin
        w_be    = mem_address[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{mem_write_data[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = mem_write_data;
      end
    endcase
  end

`ifdef CRISCV_BRIDGE_MMIO_EN
  logic [31:0] r_cycle_cnt;
  logic [7:0]  r_gpio;
  logic [1:0]  r_reg_off;
  logic        r_reg_hit;
  logic [31:0] w_reg_word;

  assign w_mmio   = (mem_address[31:28] == 4'hF);
  assign gpio_out = r_gpio;

  // Registers outside the 16-byte window read as zero.
  always_comb begin
    w_reg_word = 32'h0;
    if (r_reg_hit) begin
      case (r_reg_off)
        2'd0:    w_reg_word = {24'h0, r_gpio};
        2'd1:    w_reg_word = {24'h0, gpio_in};
        2'd2:    w_reg_word = r_cycle_cnt;
        default: w_reg_word = {31'h0, err};
      endcase
    end
  end

  assign w_local_rdata = r_misal ? 32'h0 : lane_align(w_reg_word, r_lane, r_size);

  always_ff @(posedge mclk) begin
    if (!reset) r_cycle_cnt <= 32'h0;
    else        r_cycle_cnt <= r_cycle_cnt + 32'd1;
  end
`else
  logic w_unused_ok;

  assign w_mmio        = 1'b0;
  assign gpio_out      = 8'h00;
  assign w_local_rdata = 32'h0;
  assign w_unused_ok   = ^{gpio_in, r_misal};
`endif

  always_ff @(posedge mclk) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      mem_rec       <= 1'b0;
      mem_read_data <= 32'h0;
      ram_req       <= 1'b0;
      ram_we        <= 1'b0;
      ram_be        <= 4'h0;
      ram_addr      <= '0;
      ram_wdata     <= 32'h0;
      err           <= 1'b0;
      err_addr      <= 32'h0;
      r_lane        <= 2'd0;
      r_size        <= 2'd0;
      r_rw          <= 1'b0;
      r_misal       <= 1'b0;
`ifdef CRISCV_BRIDGE_MMIO_EN
      r_gpio        <= 8'h00;
      r_reg_off     <= 2'd0;
      r_reg_hit     <= 1'b0;
`endif
    end else begin
      mem_rec <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (mem_rw_req) begin
            r_lane    <= mem_address[1:0];
            r_size    <= mem_size;
            r_rw      <= mem_rw;
            r_misal   <= w_misal;
            ram_addr  <= mem_address[ADDR_W-1:2];
            ram_we    <= mem_rw;
            ram_be    <= w_be;
            ram_wdata <= w_wdata;
`ifdef CRISCV_BRIDGE_MMIO_EN
            r_reg_off <= mem_address[3:2];
            r_reg_hit <= (mem_address[27:4] == 24'h0);
`endif
            // Misaligned and MMIO accesses both complete locally, no backend cycle.
            if (w_misal) begin
              r_state <= S_LOCAL;
              if (!err) begin
                err      <= 1'b1;
                err_addr <= mem_address;
              end
            end else if (w_mmio) begin
              r_state <= S_LOCAL;
            end else begin
              ram_req <= 1'b1;
              r_state <= S_RAM_WAIT;
            end
          end
        end
        S_RAM_WAIT: begin
          if (ram_ack) begin
            ram_req       <= 1'b0;
            mem_read_data <= r_rw ? 32'h0 : lane_align(ram_rdata, r_lane, r_size);
            mem_rec       <= 1'b1;
            r_state       <= S_RESP;
          end
        end
        S_LOCAL: begin
          mem_read_data <= r_rw ? 32'h0 : w_local_rdata;
`ifdef CRISCV_BRIDGE_MMIO_EN
          if (r_rw && !r_misal && r_reg_hit && ram_be[0]) begin
            if (r_reg_off == 2'd0) r_gpio <= ram_wdata[7:0];
            if ((r_reg_off == 2'd3) && ram_wdata[0]) err <= 1'b0;
          end
`endif
          mem_rec <= 1'b1;
          r_state <= S_RESP;
        end
        S_RESP:    r_state <= S_RELEASE;
        S_RELEASE: if (!mem_rw_req) r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_criscv_mem_bridge.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_criscv_mem_bridge: directed vectors against hand-computed results. Rev 1.0|
// +-----------------------------------------------------------------------------+
module tb_criscv_mem_bridge;

  localparam int C_ADDR_W = 16;

  logic                mclk = 1'b0;
  logic                reset = 1'b0;
  logic [31:0]         mem_address = 32'h0;
  logic                mem_rw_req = 1'b0;
  logic                mem_rw = 1'b0;
  logic [31:0]         mem_write_data = 32'h0;
  logic [1:0]          mem_size = 2'd0;
  logic [31:0]         mem_read_data;
  logic                mem_rec;
  logic [C_ADDR_W-3:0] ram_addr;
  logic                ram_req;
  logic                ram_we;
  logic [3:0]          ram_be;
  logic [31:0]         ram_wdata;
  logic [31:0]         ram_rdata = 32'h0;
  logic                ram_ack = 1'b0;
  logic [7:0]          gpio_in = 8'h00;
  logic [7:0]          gpio_out;
  logic                err;
  logic [31:0]         err_addr;

  criscv_mem_bridge #(.ADDR_W(C_ADDR_W)) dut (
    .mclk(mclk), .reset(reset),
    .mem_address(mem_address), .mem_rw_req(mem_rw_req), .mem_rw(mem_rw),
    .mem_write_data(mem_write_data), .mem_size(mem_size),
    .mem_read_data(mem_read_data), .mem_rec(mem_rec),
    .ram_addr(ram_addr), .ram_req(ram_req), .ram_we(ram_we), .ram_be(ram_be),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ack(ram_ack),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .err(err), .err_addr(err_addr)
  );

  always #5 mclk = ~mclk;

  int checks   = 0;
  int failures = 0;

  // Observations captured by xact
  int                rec_n;
  int                req_seen;
  int                extra;
  logic [31:0]       rd_val;
  logic [3:0]        cap_be;
  logic [C_ADDR_W-3:0] cap_addr;
  logic [31:0]       cap_wdata;
  logic              cap_we;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Core-side request plus a backend acking lat cycles after ram_req rises.
  // rec_n counts edges from the request being driven to mem_rec observed.
  task automatic xact(input logic rw, input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] wd, input int lat, input logic [31:0] rword,
                      input int hold);
    int reqcnt;
    reqcnt = 0;
    mem_rw_req = 1'b1; mem_rw = rw; mem_size = sz; mem_address = a; mem_write_data = wd;
    rec_n = -1; req_seen = 0; extra = 0; rd_val = 32'h0;
    cap_be = 4'h0; cap_addr = '0; cap_wdata = 32'h0; cap_we = 1'b0;
    for (int n = 1; n <= 40 && rec_n < 0; n++) begin
      @(posedge mclk); #1;
      if (ram_req) reqcnt++;
      ram_ack   = ram_req && (reqcnt == lat + 1);
      ram_rdata = ram_ack ? rword : 32'h0;
      @(negedge mclk);
      if (ram_req && req_seen == 0) begin
        req_seen = 1; cap_be = ram_be; cap_addr = ram_addr; cap_wdata = ram_wdata; cap_we = ram_we;
      end
      if (mem_rec) begin
        rec_n  = n;
        rd_val = mem_read_data;
      end
    end
    ram_ack = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(posedge mclk); #1;
      @(negedge mclk);
      if (mem_rec || ram_req) extra++;
    end
    @(posedge mclk); #1;
    mem_rw_req = 1'b0;
    @(negedge mclk);
    if (mem_rec) extra++;
    @(posedge mclk); #1;
  endtask

  initial begin
    logic [31:0] cnt_a;
    int          late_rec;

    reset = 1'b0;
    repeat (3) @(posedge mclk);
    @(negedge mclk);
    chk("rst_mem_rec", {31'h0, mem_rec}, 32'h0);
    chk("rst_rdata", mem_read_data, 32'h0);
    chk("rst_ram_req", {31'h0, ram_req}, 32'h0);
    chk("rst_ram_fields", {ram_we, ram_be, ram_addr}, 32'h0);
    chk("rst_ram_wdata", ram_wdata, 32'h0);
    chk("rst_err", {23'h0, gpio_out, err}, 32'h0);
    chk("rst_err_addr", err_addr, 32'h0);
    @(posedge mclk); #1;
    reset = 1'b1;

    // LW, backend latency 3
    xact(1'b0, 2'd2, 32'h0000_0100, 32'h0, 3, 32'hDEAD_BEEF, 0);
    chk("lw_rec_n", rec_n, 5);
    chk("lw_be", {28'h0, cap_be}, 32'hF);
    chk("lw_addr", {18'h0, cap_addr}, 32'h40);
    chk("lw_we", {31'h0, cap_we}, 32'h0);
    chk("lw_data", rd_val, 32'hDEAD_BEEF);
    chk("lw_single_pulse", extra, 0);

    xact(1'b0, 2'd0, 32'h0000_0103, 32'h0, 1, 32'h8899_AABB, 0);
    chk("lb_rec_n", rec_n, 3);
    chk("lb_be", {28'h0, cap_be}, 32'h8);
    chk("lb_data", rd_val, 32'h0000_0088);

    xact(1'b1, 2'd0, 32'h0000_0101, 32'hFFFF_FF5A, 2, 32'h0, 0);
    chk("sb_be", {28'h0, cap_be}, 32'h2);
    chk("sb_wdata", cap_wdata, 32'h5A5A_5A5A);
    chk("sb_we", {31'h0, cap_we}, 32'h1);

    xact(1'b0, 2'd1, 32'h0000_0102, 32'h0, 1, 32'h8899_AABB, 0);
    chk("lh_be", {28'h0, cap_be}, 32'hC);
    chk("lh_data", rd_val, 32'h0000_8899);

    xact(1'b1, 2'd1, 32'h0000_0100, 32'hFFFF_1234, 1, 32'h0, 0);
    chk("sh_be", {28'h0, cap_be}, 32'h3);
    chk("sh_wdata", cap_wdata, 32'h1234_1234);

    // Misaligned accesses complete locally and latch only the first address
    xact(1'b1, 2'd1, 32'h0000_0201, 32'h0, 1, 32'h0, 0);
    chk("mis_sh_noreq", req_seen, 0);
    chk("mis_sh_rec_n", rec_n, 2);
    chk("mis_sh_err", {31'h0, err}, 32'h1);
    chk("mis_sh_err_addr", err_addr, 32'h0000_0201);

    xact(1'b0, 2'd2, 32'h0000_0302, 32'h0, 1, 32'hFFFF_FFFF, 0);
    chk("mis_lw_noreq", req_seen, 0);
    chk("mis_lw_data", rd_val, 32'h0);
    chk("mis_lw_err_addr", err_addr, 32'h0000_0201);

`ifdef CRISCV_BRIDGE_MMIO_EN
    xact(1'b1, 2'd2, 32'hF000_000C, 32'h0000_0001, 1, 32'h0, 0);
    chk("mmio_clr_rec_n", rec_n, 2);
    chk("mmio_clr_err", {31'h0, err}, 32'h0);

    xact(1'b1, 2'd2, 32'hF000_0000, 32'h0000_00A5, 1, 32'h0, 0);
    chk("mmio_gpio_noreq", req_seen, 0);
    chk("mmio_gpio_out", {24'h0, gpio_out}, 32'hA5);
    xact(1'b0, 2'd2, 32'hF000_0000, 32'h0, 1, 32'h0, 0);
    chk("mmio_gpio_rd", rd_val, 32'h0000_00A5);

    gpio_in = 8'h3C;
    xact(1'b0, 2'd0, 32'hF000_0004, 32'h0, 1, 32'h0, 0);
    chk("mmio_gpio_in", rd_val, 32'h0000_003C);

    xact(1'b0, 2'd2, 32'hF000_0010, 32'h0, 1, 32'h0, 0);
    chk("mmio_hole", rd_val, 32'h0);

    xact(1'b0, 2'd2, 32'hF000_0008, 32'h0, 1, 32'h0, 0);
    cnt_a = rd_val;
    repeat (6) @(posedge mclk);
    #1;
    xact(1'b0, 2'd2, 32'hF000_0008, 32'h0, 1, 32'h0, 0);
    chk("mmio_cnt_delta", rd_val - cnt_a, 32'd10);
`else
    xact(1'b0, 2'd2, 32'hF000_0100, 32'h0, 1, 32'h1122_3344, 0);
    chk("alias_req", req_seen, 1);
    chk("alias_addr", {18'h0, cap_addr}, 32'h40);
    chk("alias_data", rd_val, 32'h1122_3344);
    chk("alias_gpio", {24'h0, gpio_out}, 32'h0);
`endif

    // Request held after completion must not start a second transaction
    xact(1'b0, 2'd2, 32'h0000_0104, 32'h0, 1, 32'h0BAD_F00D, 4);
    chk("hold_rec_n", rec_n, 3);
    chk("hold_data", rd_val, 32'h0BAD_F00D);
    chk("hold_no_second", extra, 0);

    // Reset while waiting on the backend; a late ack must be ignored
    mem_rw_req = 1'b1; mem_rw = 1'b0; mem_size = 2'd2; mem_address = 32'h0000_0400;
    @(posedge mclk); #1;
    chk("rstmid_req_up", {31'h0, ram_req}, 32'h1);
    reset = 1'b0;
    @(posedge mclk); #1;
    chk("rstmid_req_down", {31'h0, ram_req}, 32'h0);
    chk("rstmid_err", {31'h0, err}, 32'h0);
    mem_rw_req = 1'b0;
    reset = 1'b1;
    @(posedge mclk); #1;
    ram_ack = 1'b1; ram_rdata = 32'hCAFE_CAFE;
    late_rec = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge mclk);
      if (mem_rec || ram_req) late_rec++;
      @(posedge mclk); #1;
      ram_ack = 1'b0;
    end
    chk("rstmid_late_ack", late_rec, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
